inv_map_affine_word: RTL and testbench

- Output stage of the composite-field S-box datapath. Takes a 32-bit word of bytes in the GF((2^4)^2) basis, normally produced after composite-field inversion.
- Maps each byte back to the GF(2^8) polynomial basis using the inverse isomorphism δ^-1, the inverse of the forward map applied at S-box entry.
- Optionally applies the AES forward affine transform to each mapped byte.
- Processes one byte per clock under a valid/ready handshake, so the design needs only one δ^-1/affine instance.

---
 rtl/inv_map_affine_word.sv | 116 +++++++++++
 tb/tb_inv_map_affine_word.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_map_affine_word.sv
// inv_map_affine_word
//   Output stage of the composite-field S-box datapath. A word of NBYTES bytes
//   in the GF((2^4)^2) basis is accepted, and each byte is mapped back to the
//   GF(2^8) polynomial basis through delta^-1. The AES forward affine transform
//   is then optionally applied. Bytes are handled one per clock, LSB first,
//   through a single shared mapping instance.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any word in flight
//   in_valid   in_word/in_affine valid
//   in_ready   block can accept a word (IDLE only)
//   in_word    composite-basis bytes, byte k = in_word[8k+7:8k]
//   in_affine  1 = delta^-1 then affine, 0 = delta^-1 only (sampled at accept)
//   out_valid  out_word valid (DONE)
//   out_ready  downstream accepts out_word
//   out_word   polynomial-basis result, same byte order
//   busy       high in BUSY or DONE
module inv_map_affine_word #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_word,
  input  logic         in_affine,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_word,
  output logic         busy
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  word_p0;
  logic          affine_p0;
  logic [W-1:0]  out_word_p1;
  logic [7:0]    cur_byte;
  logic [7:0]    mapped_byte;

  // Inverse isomorphism: composite basis back to polynomial basis.
  function automatic logic [7:0] delta_inv(input logic [7:0] c);
    logic [7:0] a;
    a[7] = c[4] ^ c[1];
    a[6] = c[7] ^ c[6] ^ c[5] ^ c[3] ^ c[1] ^ c[0];
    a[5] = c[7] ^ c[6] ^ c[5] ^ c[3] ^ c[2] ^ c[0];
    a[4] = c[6] ^ c[1];
    a[3] = c[6] ^ c[5] ^ c[4] ^ c[3] ^ c[2] ^ c[1];
    a[2] = c[7] ^ c[5] ^ c[4] ^ c[1];
    a[1] = c[5] ^ c[1];
    a[0] = c[2];
    return a;
  endfunction

  // AES forward affine: a ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] aes_affine(input logic [7:0] a);
    return a
         ^ {a[6:0], a[7]}
         ^ {a[5:0], a[7:6]}
         ^ {a[4:0], a[7:5]}
         ^ {a[3:0], a[7:4]}
         ^ 8'h63;
  endfunction

  always_comb begin
    cur_byte    = word_p0[8*cnt +: 8];
    mapped_byte = delta_inv(cur_byte);
    if (affine_p0) mapped_byte = aes_affine(mapped_byte);
  end

  // Stage p0: word/mode capture at accept; stage p1: per-byte result writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      word_p0     <= '0;
      affine_p0   <= 1'b0;
      out_word_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_p0   <= in_word;
            affine_p0 <= in_affine;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          out_word_p1[8*cnt +: 8] <= mapped_byte;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_word  = out_word_p1;

endmodule

// File: tb/tb_inv_map_affine_word.sv
module tb_inv_map_affine_word;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_word;
  logic         in_affine;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         busy;

  always #5 clk = ~clk;

  inv_map_affine_word #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_affine (in_affine),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] dinv_tab [256];
  logic [7:0] fwd_tab  [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // delta^-1 as a GF(2) matrix: bit i of the result is the parity of c masked by row i.
  function automatic logic [7:0] ref_dinv(input logic [7:0] c);
    logic [7:0] rows [8];
    logic [7:0] a;
    rows = '{8'h04, 8'h22, 8'hB2, 8'h7E, 8'h42, 8'hED, 8'hEB, 8'h12};
    for (int i = 0; i < 8; i++) a[i] = ^(c & rows[i]);
    return a;
  endfunction

  function automatic logic [7:0] ref_aff(input logic [7:0] a);
    int v;
    int s;
    v = a;
    s = v;
    for (int r = 1; r <= 4; r++) s = s ^ (((v << r) | (v >> (8 - r))) & 255);
    s = s ^ 'h63;
    return s[7:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w, input logic aff);
    logic [31:0] r;
    logic [7:0]  b;
    for (int k = 0; k < NB; k++) begin
      b = ref_dinv(w[8*k +: 8]);
      r[8*k +: 8] = aff ? ref_aff(b) : b;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word and run until DONE (or a bounded timeout); returns out_word.
  task automatic run_word(input logic [31:0] w, input logic aff, output logic [31:0] res);
    int lat;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_word   = w;
    in_affine = aff;
    tick();
    in_valid = 1'b0;
    in_word  = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      check("busy_in_ready", {31'b0, in_ready}, 32'd0);
      check("busy_flag", {31'b0, busy}, 32'd1);
      in_affine = 1'($urandom);
      tick();
      lat++;
    end
    check("latency", lat, NB + 1);
    check("done_in_ready", {31'b0, in_ready}, 32'd0);
    res = out_word;
  endtask

  task automatic complete_word();
    out_ready = 1'b1;
    tick();
    check("hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("hs_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] w;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        aff;
    logic [31:0] q[$];
    int          last_acc;
    int          n_acc;
    bit          acc_pending;

    for (int c = 0; c < 256; c++) begin
      dinv_tab[c] = ref_dinv(8'(c));
      fwd_tab[dinv_tab[c]] = 8'(c);
    end

    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_affine = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors.
    run_word(32'h00A9FF00, 1'b1, res);
    check("vec_affine", res, 32'h635D7C63);
    complete_word();
    run_word(32'h00A9FF00, 1'b0, res);
    check("vec_plain", res, 32'h00020100);
    complete_word();

    // Round trip over all 256 byte values, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int g = 0; g < 64; g++) begin
        for (int k = 0; k < 4; k++) begin
          w[8*k +: 8]    = fwd_tab[4*g + k];
          exp0[8*k +: 8] = 8'(4*g + k);
          exp1[8*k +: 8] = ref_aff(8'(4*g + k));
        end
        run_word(w, 1'(m), res);
        check(m == 0 ? "roundtrip_plain" : "roundtrip_affine", res, m == 0 ? exp0 : exp1);
        complete_word();
      end
    end

    // Random words.
    for (int i = 0; i < 40; i++) begin
      w   = $urandom;
      aff = 1'($urandom);
      run_word(w, aff, res);
      check("random_word", res, ref_word(w, aff));
      complete_word();
    end

    // Back-pressure: output must hold while out_ready is low.
    out_ready = 1'b0;
    w   = $urandom;
    aff = 1'($urandom);
    run_word(w, aff, res);
    check("bp_word", res, ref_word(w, aff));
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'($urandom);
      in_word   = $urandom;
      in_affine = 1'($urandom);
      tick();
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_out_word", out_word, res);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    complete_word();

    // Reset in the second BUSY cycle aborts the word.
    in_valid  = 1'b1;
    in_word   = 32'h1234_5678 | 32'h0000_0001;
    in_affine = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_out_word", out_word, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end

    // Back-to-back words with in_valid held high; mode alternates per word.
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_word     = $urandom;
    in_affine   = 1'b0;
    last_acc    = -1;
    n_acc       = 0;
    acc_pending = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) check("b2b_unexpected_out", 32'd1, 32'd0);
        else check("b2b_word", out_word, q.pop_front());
      end
      if (acc_pending) begin
        in_word     = $urandom;
        in_affine   = 1'(n_acc);
        acc_pending = 1'b0;
      end
      if (in_ready === 1'b1 && in_valid === 1'b1) begin
        q.push_back(ref_word(in_word, in_affine));
        if (last_acc >= 0) check("b2b_gap", c - last_acc, NB + 2);
        last_acc    = c;
        n_acc++;
        acc_pending = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      if (out_valid === 1'b1) check("b2b_drain_word", out_word, q.pop_front());
      tick();
    end
    check("b2b_all_out", q.size(), 32'd0);
    check("b2b_accepts", (n_acc >= 8) ? 32'd1 : 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
